// File: rtl/uart_echo_fifo_if.sv
// UART echo bridge bus: receiver strobe/data in, transmitter request/data out,
// plus the mode/overflow control and status lines.
interface uart_echo_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic                     rx_valid;
  logic [DATA_W-1:0]        rx_data;
  logic                     tx_busy;
  logic [1:0]               mode;
  logic                     ovf_clr;
  logic                     tx_req;
  logic [DATA_W-1:0]        tx_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;

  // Environment side: receiver, transmitter status and host control
  modport master (
    output rx_valid, rx_data, tx_busy, mode, ovf_clr,
    input  tx_req, tx_data, fifo_count, overflow
  );

  // Bridge side
  modport slave (
    input  rx_valid, rx_data, tx_busy, mode, ovf_clr,
    output tx_req, tx_data, fifo_count, overflow
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo bridge: received bytes are queued in a FIFO and a small
// TX FSM pops them one at a time, applies the mode transform and drives a
// stretched transmit request so bursts survive a busy transmitter.
module uart_echo_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int REQ_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_echo_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(REQ_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [AW:0]       count;
  logic [1:0]        state;
  logic [CW-1:0]     reqCnt;
  logic [DATA_W-1:0] txData;
  logic              txReq;
  logic              ovf;

  logic              full, pop, push, drop;
  logic [DATA_W-1:0] popByte;

  // Byte transform applied at pop time; mode 11 never reaches here
  function automatic logic [DATA_W-1:0] xform(input logic [1:0] m,
                                              input logic [DATA_W-1:0] d);
    case (m)
      2'b01:   xform = d + DATA_W'(1);
      2'b10:   xform = ~d;
      default: xform = d;
    endcase
  endfunction

  // A pop frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when the FSM pops alongside it.
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = (state == IDLE) && (count != '0) && !bus.tx_busy;
  assign push    = bus.rx_valid && (!full || pop);
  assign drop    = bus.rx_valid && full && !pop;
  assign popByte = mem[rdPtr];

  // FIFO storage, no reset needed: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= bus.rx_data;
  end

  // Pointers and registered occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf <= 1'b0;
    else if (drop)        ovf <= 1'b1;
    else if (bus.ovf_clr) ovf <= 1'b0;
  end

  // TX FSM: pop, hold tx_req for REQ_CYCLES, then wait for the transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      reqCnt <= '0;
      txReq  <= 1'b0;
      txData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && bus.mode != 2'b11) begin
            txData <= xform(bus.mode, popByte);
            txReq  <= 1'b1;
            reqCnt <= CW'(1);
            state  <= REQ;
          end
        end
        REQ: begin
          if (reqCnt == CW'(REQ_CYCLES)) begin
            txReq <= 1'b0;
            state <= WAIT;
          end else begin
            reqCnt <= reqCnt + CW'(1);
          end
        end
        WAIT: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_req     = txReq;
  assign bus.tx_data    = txData;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo with a simple transmitter model:
// tx_busy rises one cycle into each tx_req pulse and stays high 10 cycles.
module tb_uart_echo_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;
  uart_echo_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_echo_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REQ_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic              busyForce;
  int                busyCnt;
  logic              prevReq;
  int                curLen;
  int                lastLen;
  int                reqTotal;
  logic [DATA_W-1:0] txQ [$];

  assign bus.tx_busy = busyForce | (busyCnt != 0);

  // Transmitter model and tx monitor; samples pre-edge DUT outputs
  always @(posedge clk) begin
    prevReq <= bus.tx_req;
    if (bus.tx_req && !prevReq) txQ.push_back(bus.tx_data);
    if (bus.tx_req) begin
      curLen   <= curLen + 1;
      reqTotal <= reqTotal + 1;
    end else if (prevReq) begin
      lastLen <= curLen;
      curLen  <= 0;
    end
    if (busyCnt != 0)                 busyCnt <= busyCnt - 1;
    else if (bus.tx_req && !prevReq)  busyCnt <= 10;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    step(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int done;
    done = 0;
    for (int i = 0; i < maxCycles; i++) begin
      if (bus.fifo_count == 0 && !bus.tx_req && busyCnt == 0) begin
        done = 1;
        break;
      end
      step(1);
    end
    if (done == 0) chk("idle_timeout", 32'd0, 32'd1);
    step(3);
  endtask

  int qSnap;
  int reqSnap;

  initial begin
    rst          = 1'b1;
    busyForce    = 1'b0;
    busyCnt      = 0;
    prevReq      = 1'b0;
    curLen       = 0;
    lastLen      = 0;
    reqTotal     = 0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.mode     = 2'b00;
    bus.ovf_clr  = 1'b0;
    step(2);
    chk("rst_req",   32'(bus.tx_req),     32'd0);
    chk("rst_data",  32'(bus.tx_data),    32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow),   32'd0);
    rst = 1'b0;
    step(2);

    // Single echo, mode 00, with latency checks
    sendByte(8'h41);
    chk("echo_cnt1",  32'(bus.fifo_count), 32'd1);
    chk("echo_noreq", 32'(bus.tx_req),     32'd0);
    step(1);
    chk("echo_req",   32'(bus.tx_req),     32'd1);
    chk("echo_data",  32'(bus.tx_data),    32'h41);
    chk("echo_cnt0",  32'(bus.fifo_count), 32'd0);
    waitIdle(60);
    chk("echo_len",   32'(lastLen),        32'd3);
    chk("echo_qsize", 32'(txQ.size()),     32'd1);
    chk("echo_qbyte", 32'(txQ[0]),         32'h41);

    // Burst of 20 while transmitter busy: 16 kept, 4 dropped
    txQ.delete();
    busyForce = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.rx_data  = 8'(i);
      bus.rx_valid = 1'b1;
      step(1);
    end
    bus.rx_valid = 1'b0;
    chk("burst_cnt", 32'(bus.fifo_count), 32'd16);
    chk("burst_ovf", 32'(bus.overflow),   32'd1);
    step(1);
    busyForce = 1'b0;
    waitIdle(600);
    chk("burst_qsize", 32'(txQ.size()), 32'd16);
    for (int i = 0; i < 16 && i < txQ.size(); i++)
      chk($sformatf("burst_ord%0d", i), 32'(txQ[i]), 32'(i));
    chk("burst_ovf_hold", 32'(bus.overflow), 32'd1);

    // ovf_clr alone clears the flag
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("clr_alone", 32'(bus.overflow), 32'd0);

    // Mode sampled at pop: a change during REQ leaves tx_data alone
    txQ.delete();
    bus.mode = 2'b00;
    sendByte(8'h10);
    step(1);
    bus.mode = 2'b10;
    step(1);
    chk("mode_late", 32'(bus.tx_data), 32'h10);
    waitIdle(60);

    // Transforms
    bus.mode = 2'b01;
    sendByte(8'hFF);
    waitIdle(60);
    chk("mode_inc", 32'(txQ[txQ.size()-1]), 32'h00);
    bus.mode = 2'b10;
    sendByte(8'h5A);
    waitIdle(60);
    chk("mode_inv", 32'(txQ[txQ.size()-1]), 32'hA5);

    // Discard mode drains without any request
    busyForce = 1'b1;
    bus.mode  = 2'b11;
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h03);
    chk("disc_fill", 32'(bus.fifo_count), 32'd3);
    qSnap   = txQ.size();
    reqSnap = reqTotal;
    busyForce = 1'b0;
    waitIdle(40);
    chk("disc_cnt",  32'(bus.fifo_count), 32'd0);
    chk("disc_req",  32'(reqTotal),       32'(reqSnap));
    chk("disc_q",    32'(txQ.size()),     32'(qSnap));

    // Full FIFO with simultaneous pop and push
    bus.mode  = 2'b00;
    busyForce = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.rx_data  = 8'(8'h80 + i);
      bus.rx_valid = 1'b1;
      step(1);
    end
    bus.rx_valid = 1'b0;
    chk("full_cnt", 32'(bus.fifo_count), 32'd16);
    chk("full_ovf", 32'(bus.overflow),   32'd0);
    qSnap        = txQ.size();
    busyForce    = 1'b0;
    bus.rx_data  = 8'hC0;
    bus.rx_valid = 1'b1;
    step(1);
    chk("simul_cnt",  32'(bus.fifo_count), 32'd16);
    chk("simul_ovf",  32'(bus.overflow),   32'd0);
    chk("simul_req",  32'(bus.tx_req),     32'd1);
    chk("simul_data", 32'(bus.tx_data),    32'h80);

    // Drop together with ovf_clr: drop wins
    bus.rx_data = 8'hD0;
    bus.ovf_clr = 1'b1;
    step(1);
    bus.rx_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    chk("drop_clr_ovf", 32'(bus.overflow),   32'd1);
    chk("drop_clr_cnt", 32'(bus.fifo_count), 32'd16);
    chk("midreq_req",   32'(bus.tx_req),     32'd1);
    chk("midreq_q",     32'(txQ.size()),     32'(qSnap + 1));
    chk("midreq_byte",  32'(txQ[txQ.size()-1]), 32'h80);

    // Asynchronous reset in the middle of a request
    #2 rst = 1'b1;
    #1;
    chk("arst_req",   32'(bus.tx_req),     32'd0);
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    chk("arst_ovf",   32'(bus.overflow),   32'd0);
    chk("arst_data",  32'(bus.tx_data),    32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    chk("post_rst_req", 32'(bus.tx_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
